// File: rtl/chrono_pkg.sv
// Shared constants and helpers for the chrono timer block.
// No logic; elaboration-time only.
// No flow control.
package chrono_pkg;

  // Bit positions inside control_register.
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_DOWN   = 2;
  localparam int CTRL_RELOAD = 3;
  localparam int CTRL_LOAD   = 4;
  localparam int CTRL_WIDTH  = 8;

  // Clock cycles per count period; 0 flags an unusable tick rate.
  function automatic int calc_div(input int clock_hz, input int tick_hz);
    if (tick_hz <= 0) begin
      return 0;
    end
    return clock_hz / tick_hz;
  endfunction

endpackage

// File: rtl/chrono_lap_fifo.sv
// Lap capture FIFO, first-word-fall-through head on data/valid.
// Push visible at head one cycle after the write; pop exposes the next head next cycle.
// Push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module chrono_lap_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("chrono_lap_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  // Storage array; no reset needed since valid gates the head.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/chrono_timer.sv
// Prescaled up/down counter with sticky expiry and a lap capture FIFO.
// tick and the new count appear together one cycle after the prescaler's last step.
// No backpressure: laps that arrive while the FIFO is full are dropped and flagged.
module chrono_timer
  import chrono_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TICK_HZ         = 1000,
  parameter int COUNT_WIDTH     = 32,
  parameter int LAP_DEPTH       = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [CTRL_WIDTH-1:0]        control_register,
  input  logic [COUNT_WIDTH-1:0]       load_value,
  input  logic                         lap_req,
  input  logic                         lap_rd,
  output logic [COUNT_WIDTH-1:0]       count,
  output logic                         tick,
  output logic                         expired,
  output logic [COUNT_WIDTH-1:0]       lap_data,
  output logic                         lap_valid,
  output logic [$clog2(LAP_DEPTH):0]   lap_level,
  output logic                         lap_overflow
);

  localparam int DIV = calc_div(CLOCK_FREQUENCY, TICK_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("chrono_timer: CLOCK_FREQUENCY/TICK_HZ must be at least 2");
  end

  logic          enable;
  logic          clear;
  logic          down;
  logic          reload;
  logic          load;
  logic          unused_ctrl;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [PW-1:0] prescaler;
  logic          presc_last;
  logic          lap_full;

  assign enable      = control_register[CTRL_ENABLE];
  assign clear       = control_register[CTRL_CLEAR];
  assign down        = control_register[CTRL_DOWN];
  assign reload      = control_register[CTRL_RELOAD];
  assign load        = control_register[CTRL_LOAD];
  assign unused_ctrl = ^control_register[CTRL_WIDTH-1:CTRL_LOAD+1];
  assign presc_last  = (prescaler == PW'(DIV - 1));

  // Reset asserts immediately but releases two clocks later, aligned to the clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  // Prescaler and counter: clear beats load, load beats the periodic update.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      count     <= '0;
      tick      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        prescaler <= '0;
        count     <= '0;
        expired   <= 1'b0;
      end else if (load) begin
        prescaler <= '0;
        count     <= load_value;
        expired   <= 1'b0;
      end else if (enable) begin
        if (presc_last) begin
          prescaler <= '0;
          tick      <= 1'b1;
          if (!down) begin
            count <= count + 1'b1;
          end else if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            // Reaching zero never wraps; it either reloads or parks at zero.
            expired <= 1'b1;
            count   <= reload ? load_value : '0;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  // Sticky overflow when a lap is refused by a full FIFO.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lap_overflow <= 1'b0;
    end else if (clear) begin
      lap_overflow <= 1'b0;
    end else if (lap_req && lap_full && !lap_rd) begin
      lap_overflow <= 1'b1;
    end
  end

  // Laps capture the registered count, i.e. the value before this edge's update.
  chrono_lap_fifo #(
    .WIDTH (COUNT_WIDTH),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clock     (clock),
    .reset_n   (rst_n),
    .push      (lap_req),
    .push_data (count),
    .pop       (lap_rd),
    .data      (lap_data),
    .valid     (lap_valid),
    .level     (lap_level),
    .full      (lap_full)
  );

endmodule

// File: tb/tb_chrono_timer.sv
// Self-checking bench for chrono_timer with a behavioural reference model.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Every cycle driven through step() is compared against the model.
module tb_chrono_timer;

  localparam int DIV = 10;
  localparam int CW  = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [7:0]    control_register;
  logic [CW-1:0] load_value;
  logic          lap_req;
  logic          lap_rd;
  logic [CW-1:0] count;
  logic          tick;
  logic          expired;
  logic [CW-1:0] lap_data;
  logic          lap_valid;
  logic [2:0]    lap_level;
  logic          lap_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int            m_pre;
  logic [CW-1:0] m_cnt;
  logic          m_tick;
  logic          m_exp;
  logic          m_ovf;
  logic [CW-1:0] m_q[$];

  chrono_timer #(
    .CLOCK_FREQUENCY (10000),
    .TICK_HZ         (1000),
    .COUNT_WIDTH     (CW),
    .LAP_DEPTH       (4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .control_register (control_register),
    .load_value       (load_value),
    .lap_req          (lap_req),
    .lap_rd           (lap_rd),
    .count            (count),
    .tick             (tick),
    .expired          (expired),
    .lap_data         (lap_data),
    .lap_valid        (lap_valid),
    .lap_level        (lap_level),
    .lap_overflow     (lap_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre  = 0;
    m_cnt  = '0;
    m_tick = 1'b0;
    m_exp  = 1'b0;
    m_ovf  = 1'b0;
    m_q.delete();
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic [7:0] ctrl, input logic [CW-1:0] lv,
                            input logic lreq, input logic lrd);
    bit en, clr, dn, ar, ld, was_full, can_pop;
    en  = ctrl[0];
    clr = ctrl[1];
    dn  = ctrl[2];
    ar  = ctrl[3];
    ld  = ctrl[4];
    was_full = (m_q.size() == 4);
    can_pop  = (m_q.size() != 0);
    if (lreq && was_full && !lrd) m_ovf = 1'b1;
    if (lrd && can_pop) void'(m_q.pop_front());
    if (lreq && (!was_full || lrd)) m_q.push_back(m_cnt);
    m_tick = 1'b0;
    if (clr) begin
      m_pre = 0;
      m_cnt = '0;
      m_exp = 1'b0;
      m_ovf = 1'b0;
    end else if (ld) begin
      m_pre = 0;
      m_cnt = lv;
      m_exp = 1'b0;
    end else if (en) begin
      m_pre = m_pre + 1;
      if (m_pre == DIV) begin
        m_pre  = 0;
        m_tick = 1'b1;
        if (!dn) begin
          m_cnt = m_cnt + 8'd1;
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 8'd1;
        end else begin
          m_exp = 1'b1;
          m_cnt = ar ? lv : 8'd0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("count", count, m_cnt);
    check("tick", tick, m_tick);
    check("expired", expired, m_exp);
    check("lap_level", lap_level, m_q.size());
    check("lap_valid", lap_valid, m_q.size() != 0);
    check("lap_overflow", lap_overflow, m_ovf);
    if (m_q.size() != 0) check("lap_data", lap_data, m_q[0]);
  endtask

  task automatic step(input logic [7:0] ctrl, input logic [CW-1:0] lv,
                      input logic lreq, input logic lrd);
    control_register = ctrl;
    load_value       = lv;
    lap_req          = lreq;
    lap_rd           = lrd;
    @(posedge clock);
    model_edge(ctrl, lv, lreq, lrd);
    #1;
    compare_all();
    control_register = 8'h00;
    lap_req          = 1'b0;
    lap_rd           = 1'b0;
  endtask

  task automatic run_until_tick(input logic [7:0] ctrl, input logic [CW-1:0] lv);
    int n = 0;
    do begin
      step(ctrl, lv, 1'b0, 1'b0);
      n++;
    end while (!m_tick && n < 50);
    if (!m_tick) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int ticks;
    int last_tick;
    int good_gaps;
    int down_seq[4];
    logic [CW-1:0] fill_vals[4];
    logic [CW-1:0] exp_pop[4];
    logic [7:0] rc;
    bit mode_down;

    reset_n          = 1'b0;
    control_register = 8'h00;
    load_value       = '0;
    lap_req          = 1'b0;
    lap_rd           = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", count, 0);
    check("rst_tick", tick, 0);
    check("rst_expired", expired, 0);
    check("rst_level", lap_level, 0);
    check("rst_valid", lap_valid, 0);
    check("rst_overflow", lap_overflow, 0);

    // Release with enable held: first tick no sooner than DIV cycles later.
    @(negedge clock);
    control_register = 8'h01;
    reset_n = 1'b1;
    lat = 0;
    while (tick !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("first_tick_latency_ok", (lat >= DIV) && (lat < 100), 1);
    step(8'h02, 8'd0, 1'b0, 1'b0);

    // Up-count: 100 enabled cycles give 10 evenly spaced ticks.
    ticks = 0;
    last_tick = -1;
    good_gaps = 0;
    for (int i = 1; i <= 100; i++) begin
      step(8'h01, 8'd0, 1'b0, 1'b0);
      if (tick === 1'b1) begin
        if (last_tick >= 0 && i - last_tick == DIV) good_gaps++;
        last_tick = i;
        ticks++;
      end
    end
    check("up_count_100", count, 10);
    check("up_tick_total", ticks, 10);
    check("up_tick_gaps", good_gaps, 9);
    repeat (25) step(8'h00, 8'd0, 1'b0, 1'b0);
    check("up_hold_disabled", count, 10);

    // Down-count from 3 to expiry, then auto-reload.
    step(8'h10, 8'd3, 1'b0, 1'b0);
    check("down_load", count, 3);
    down_seq = '{2, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      run_until_tick(8'h05, 8'd3);
      check("down_seq", count, down_seq[i]);
      check("down_expired_flag", expired, (i == 3));
    end
    run_until_tick(8'h0D, 8'd3);
    check("down_autoreload", count, 3);
    check("down_expired_sticky", expired, 1);

    // Clear and load together: clear wins.
    step(8'h12, 8'd77, 1'b0, 1'b0);
    check("clear_load_count", count, 0);
    check("clear_load_expired", expired, 0);

    // Silent wrap from 255.
    step(8'h10, 8'd255, 1'b0, 1'b0);
    run_until_tick(8'h01, 8'd0);
    check("up_wrap", count, 0);

    // Five laps at counts 1..5 into a depth-4 FIFO.
    for (int k = 1; k <= 5; k++) begin
      run_until_tick(8'h01, 8'd0);
      step(8'h01, 8'd0, 1'b1, 1'b0);
    end
    check("lap_full_level", lap_level, 4);
    check("lap_overflow_set", lap_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("lap_read", lap_data, i + 1);
      step(8'h00, 8'd0, 1'b0, 1'b1);
    end
    check("lap_drained_level", lap_level, 0);
    step(8'h00, 8'd0, 1'b0, 1'b1);
    check("lap_empty_read_level", lap_level, 0);
    check("lap_empty_read_valid", lap_valid, 0);
    check("lap_overflow_sticky", lap_overflow, 1);

    // Push and pop together while full.
    step(8'h02, 8'd0, 1'b0, 1'b0);
    fill_vals = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int i = 0; i < 4; i++) begin
      step(8'h10, fill_vals[i], 1'b0, 1'b0);
      step(8'h00, 8'd0, 1'b1, 1'b0);
    end
    step(8'h10, 8'd50, 1'b0, 1'b0);
    step(8'h00, 8'd0, 1'b1, 1'b1);
    check("pushpop_level", lap_level, 4);
    check("pushpop_overflow", lap_overflow, 0);
    exp_pop = '{8'd20, 8'd30, 8'd40, 8'd50};
    for (int i = 0; i < 4; i++) begin
      check("pushpop_order", lap_data, exp_pop[i]);
      step(8'h00, 8'd0, 1'b0, 1'b1);
    end

    // Randomised traffic against the model.
    mode_down = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mode_down = ~mode_down;
      rc = 8'($urandom) & 8'hE0;
      rc[0] = ($urandom_range(0, 7) != 0);
      rc[1] = ($urandom_range(0, 99) == 0);
      rc[2] = mode_down;
      rc[3] = ($urandom_range(0, 1) == 0);
      rc[4] = ($urandom_range(0, 59) == 0);
      step(rc, 8'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 6) == 0));
    end

    // Asynchronous reset between edges.
    step(8'h10, 8'd42, 1'b0, 1'b0);
    step(8'h01, 8'd0, 1'b1, 1'b0);
    step(8'h01, 8'd0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_tick", tick, 0);
    check("arst_expired", expired, 0);
    check("arst_level", lap_level, 0);
    check("arst_valid", lap_valid, 0);
    check("arst_overflow", lap_overflow, 0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    repeat (25) step(8'h01, 8'd0, 1'b0, 1'b0);
    check("post_reset_count", count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chrono_timer.md
CHRONO_TIMER -- requirements
Module: chrono_timer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, input clock rate in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, count rate in Hz; DIV = CLOCK_FREQUENCY/TICK_HZ, and DIV >= 2 SHALL be enforced at elaboration.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of the counter and of the lap entries.
REQ-004 SHALL have parameter LAP_DEPTH, default 4, lap FIFO entries; it SHALL be a power of 2, >= 2.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port control_register, input, 8, with these bits:
- [0] enable
- [1] clear
- [2] down mode
- [3] auto-reload
- [4] load
- [7:5] reserved, ignored
REQ-008 SHALL have port load_value, input, COUNT_WIDTH, preset for load and auto-reload.
REQ-009 SHALL have port lap_req, input, 1, one-cycle pulse capturing count into the lap FIFO.
REQ-010 SHALL have port lap_rd, input, 1, pops the FIFO head.
REQ-011 SHALL have port count, output reg, COUNT_WIDTH, the current count.
REQ-012 SHALL have port tick, output reg, 1, one-cycle pulse on each count update period.
REQ-013 SHALL have port expired, output reg, 1, sticky flag for a down-count reaching zero.
REQ-014 SHALL have ports lap_data, output, COUNT_WIDTH, and lap_valid, output, 1; they form a first-word-fall-through head.
REQ-015 SHALL have ports lap_level, output, $clog2(LAP_DEPTH)+1 bits, and lap_overflow, output reg, 1, sticky.

Function
REQ-016 The prescaler SHALL advance 0..DIV-1 and wrap only while enable=1; it holds while enable=0.
REQ-017 tick SHALL be high for exactly the cycle after the prescaler is at DIV-1 with enable=1, so there is one tick per DIV enabled cycles.
REQ-018 Per-cycle priority SHALL be clear > load > tick update.
REQ-019 clear SHALL zero the prescaler, count, expired and lap_overflow, and SHALL not flush the FIFO.
REQ-020 load SHALL set count=load_value, zero the prescaler and zero expired.
REQ-021 On tick in up mode, count SHALL become count+1 modulo 2^COUNT_WIDTH; wrap SHALL be silent.
REQ-022 On tick in down mode with count>0, count SHALL become count-1.
REQ-023 On tick in down mode with count==0:
- expired SHALL be set to 1;
- count SHALL become load_value if auto-reload=1, otherwise it SHALL hold at 0;
- no underflow wrap SHALL occur.
REQ-024 A change of the down mode bit SHALL take effect on the next tick, with no count change.
REQ-025 lap_req SHALL capture the registered count value present at that edge, i.e. the pre-update value.
REQ-026 A lap_req while the FIFO is full and lap_rd=0 SHALL be dropped, SHALL set lap_overflow, and SHALL leave the contents unchanged.
REQ-027 A lap_req while full with lap_rd=1 SHALL pop and push together, with level unchanged.
REQ-028 A lap_rd while empty SHALL be ignored; lap_data is don't-care when lap_valid=0.
REQ-029 A simultaneous push and pop while not empty SHALL leave lap_level unchanged and preserve order.
REQ-030 lap_valid SHALL equal (lap_level != 0), and lap_data SHALL reflect a new head the cycle after the pop.

Reset
REQ-031 reset_n=0 SHALL asynchronously force:
- prescaler, count and lap_level to 0;
- FIFO pointers to 0;
- tick, expired and lap_overflow to 0.
REQ-032 Reset deassertion SHALL be synchronised so the first count activity occurs at least DIV cycles after release with enable held high.

Structure
REQ-033 Package chrono_pkg SHALL hold the control-bit index constants (CTRL_ENABLE=0 through CTRL_LOAD=4) and a function computing DIV.
REQ-034 The lap FIFO SHALL be sub-module chrono_lap_fifo, parameters WIDTH and DEPTH, with push, pop, data, valid, level and full.
REQ-035 The prescaler and counter logic SHALL reside in chrono_timer.

Verification (CLOCK_FREQUENCY=10000, TICK_HZ=1000, so DIV=10; COUNT_WIDTH=8; LAP_DEPTH=4)
REQ-036 Up-count: enable=1 for 100 cycles -> count=10 and exactly 10 tick pulses, spaced 10 cycles apart; enable=0 -> count holds.
REQ-037 Down-count: load_value=3, load, then down=1, enable=1 -> counts 3,2,1,0; the next tick sets expired=1 and count holds at 0; with auto-reload=1 the count becomes 3 instead.
REQ-038 Wrap and priority: load 255, up mode, one tick -> count=0; clear and load asserted in the same cycle -> count=0 and expired=0.
REQ-039 Laps: 5 lap_req pulses at count 1,2,3,4,5 without reads -> lap_level=4 and lap_overflow=1; reads return 1,2,3,4; a further read while empty changes nothing.
REQ-040 Push/pop while full: full FIFO, lap_req and lap_rd in the same cycle -> level stays 4, the oldest entry is popped and the new entry lands at the tail.
REQ-041 Async reset: reset_n pulsed low mid-count, between clock edges -> all outputs are 0 immediately and the FIFO is empty.
